// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU issue/writeback sequencer.
package alu_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned RIDX_W = $clog2(NREGS);

  typedef logic [3:0]        opcode_t;
  typedef logic [RIDX_W-1:0] ridx_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb,
    StLdwb
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
module alu_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [WIDTH-1:0]         rdata1,
  output logic [WIDTH-1:0]         rdata2,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Serial operand-issue and writeback sequencer in front of a registered ALU.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = alu_pkg::WIDTH,
  parameter int unsigned NREGS   = alu_pkg::NREGS,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_load,
  input  opcode_t                  in_opcode,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic                     in_use_carry,
  input  logic [WIDTH-1:0]         in_imm,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output opcode_t                  opcode,
  output logic                     Cin,
  input  logic [WIDTH-1:0]         Y,
  input  logic                     Cout,
  output logic                     done_valid,
  output logic [$clog2(NREGS)-1:0] done_rd,
  output logic [WIDTH-1:0]         done_data,
  output logic                     carry_flag
);

  localparam int unsigned IdxW = $clog2(NREGS);
  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ALU_LAT - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  opcode_t           op_q, op_d;
  logic              cin_q, cin_d;
  logic              carry_q, carry_d;

  logic [WIDTH-1:0]  rdata1, rdata2;
  logic              rf_we;
  logic [WIDTH-1:0]  rf_wdata;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (CLK),
    .rst    (RST),
    .raddr1 (in_rs1),
    .raddr2 (in_rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (rf_wdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cin_d      = cin_q;
    carry_d    = carry_q;
    in_ready   = 1'b0;
    done_valid = 1'b0;
    done_rd    = '0;
    done_data  = '0;
    rf_we      = 1'b0;
    rf_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rd_d = in_rd;
          if (in_load) begin
            imm_d   = in_imm;
            state_d = StLdwb;
          end else begin
            // ALU inputs stay frozen here until the next accept.
            a_d     = rdata1;
            b_d     = rdata2;
            op_d    = in_opcode;
            cin_d   = in_use_carry & carry_q;
            cnt_d   = '0;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == LastCnt) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        done_valid = 1'b1;
        done_rd    = rd_q;
        done_data  = Y;
        rf_we      = 1'b1;
        rf_wdata   = Y;
        carry_d    = Cout;
        state_d    = StIdle;
      end
      StLdwb: begin
        done_valid = 1'b1;
        done_rd    = rd_q;
        done_data  = imm_q;
        rf_we      = 1'b1;
        rf_wdata   = imm_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign A          = a_q;
  assign B          = b_q;
  assign opcode     = op_q;
  assign Cin        = cin_q;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq with a behavioural registered ALU and reference model.
module tb_alu_issue_seq;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NREGS   = 8;
  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned IW      = $clog2(NREGS);

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid, in_ready, in_load, in_use_carry;
  logic [3:0]       in_opcode, opcode;
  logic [IW-1:0]    in_rd, in_rs1, in_rs2, done_rd;
  logic [WIDTH-1:0] in_imm, A, B, Y, done_data;
  logic             Cin, Cout, done_valid, carry_flag;

  always #5 CLK = ~CLK;

  alu_issue_seq #(
    .WIDTH   (WIDTH),
    .NREGS   (NREGS),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_load      (in_load),
    .in_opcode    (in_opcode),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_use_carry (in_use_carry),
    .in_imm       (in_imm),
    .A            (A),
    .B            (B),
    .opcode       (opcode),
    .Cin          (Cin),
    .Y            (Y),
    .Cout         (Cout),
    .done_valid   (done_valid),
    .done_rd      (done_rd),
    .done_data    (done_data),
    .carry_flag   (carry_flag)
  );

  // Reference ALU behaviour: returns {carry, result}.
  function automatic logic [WIDTH:0] alu_f(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH:0] r;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      4'd1:    r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      4'd7:    r = {a[0], 1'b0, a[WIDTH-1:1]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Registered ALU with ALU_LAT pipeline stages.
  logic [WIDTH:0] pipe [ALU_LAT];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(ALU_LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= alu_f(opcode, A, B, Cin);
      for (int i = 1; i < int'(ALU_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {Cout, Y} = pipe[ALU_LAT-1];

  logic [WIDTH-1:0] m_rf [NREGS];
  logic             m_carry;
  int               ncomp = 0;
  int               nfail = 0;
  logic             last_cout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) m_rf[i] = '0;
    m_carry = 1'b0;
  endtask

  task automatic run(input bit ld, input logic [3:0] op, input logic [IW-1:0] rd,
                     input logic [IW-1:0] rs1, input logic [IW-1:0] rs2, input bit uc,
                     input logic [WIDTH-1:0] imm);
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] ea, eb, exp_data;
    logic             ecin;
    int               n, exp_n;
    bit               found;
    @(negedge CLK);
    in_valid = 1'b1; in_load = ld; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_use_carry = uc; in_imm = imm;
    check("ready_before_accept", in_ready, 1);
    ea   = m_rf[rs1];
    eb   = m_rf[rs2];
    ecin = uc & m_carry;
    r    = alu_f(op, ea, eb, ecin);
    exp_data = ld ? imm : r[WIDTH-1:0];
    exp_n    = ld ? 1 : ALU_LAT + 1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 4 * ALU_LAT + 8) begin
      @(negedge CLK);
      n++;
      if (!ld) begin
        check("A_stable", A, ea);
        check("B_stable", B, eb);
        check("opcode_stable", opcode, op);
        check("Cin_stable", Cin, ecin);
      end
      if (done_valid === 1'b1) found = 1;
    end
    check("done_seen", found, 1);
    check("done_latency", n, exp_n);
    check("done_data", done_data, exp_data);
    check("done_rd", done_rd, rd);
    if (!ld) begin
      m_carry   = r[WIDTH];
      last_cout = r[WIDTH];
    end
    if (rd != '0) m_rf[rd] = exp_data;
    @(negedge CLK);
    check("done_single_pulse", done_valid, 0);
    check("ready_after_wb", in_ready, 1);
    check("carry_flag", carry_flag, m_carry);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_A"}, A, 0);
    check({tag, "_B"}, B, 0);
    check({tag, "_opcode"}, opcode, 0);
    check({tag, "_Cin"}, Cin, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_rd"}, done_rd, 0);
    check({tag, "_done_data"}, done_data, 0);
    check({tag, "_carry"}, carry_flag, 0);
  endtask

  initial begin
    in_valid = 1'b0; in_load = 1'b0; in_opcode = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_use_carry = 1'b0; in_imm = '0;
    last_cout = 1'b0;
    model_reset();

    // Reset, then idle for 10 cycles.
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("in_reset");
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_no_done", done_valid, 0);
      check("idle_ready", in_ready, 1);
    end
    check_reset_outputs("idle");

    // Loads, then a basic op depending on them.
    run(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h00FF);
    run(1'b1, 4'd0, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0001);
    run(1'b0, 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
    check("r3_add_result", m_rf[3], 16'h0100);

    // Carry chain: FFFF + 1 produces a carry consumed by the next op.
    run(1'b1, 4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'hFFFF);
    run(1'b0, 4'd0, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000);
    check("chain_cout", carry_flag, 1);
    @(negedge CLK);
    in_valid = 1'b1; in_load = 1'b0; in_opcode = 4'd0; in_rd = 3'd5;
    in_rs1 = 3'd3; in_rs2 = 3'd4; in_use_carry = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    check("chain_Cin", Cin, last_cout);
    repeat (ALU_LAT + 1) @(negedge CLK);
    check("chain_done_data", done_data, 16'h0101);
    if (m_carry) m_rf[5] = 16'h0101;
    m_carry = 1'b0;
    @(negedge CLK);

    // r0 stays zero even though the writeback reports the value.
    run(1'b1, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'hBEEF);
    run(1'b0, 4'd3, 3'd6, 3'd0, 3'd1, 1'b0, 16'h0000);
    check("r0_reads_zero_A", A, 0);

    // Randomised mix against the model.
    for (int k = 0; k < 60; k++) begin
      run(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), IW'($urandom),
          IW'($urandom), IW'($urandom), 1'($urandom), WIDTH'($urandom));
    end

    // Reset while executing: no writeback, everything back to reset values.
    run(1'b1, 4'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16'h1234);
    @(negedge CLK);
    in_valid = 1'b1; in_load = 1'b0; in_opcode = 4'd0; in_rd = 3'd7;
    in_rs1 = 3'd7; in_rs2 = 3'd7; in_use_carry = 1'b0;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    @(negedge CLK);
    check("exec_not_ready", in_ready, 0);
    RST = 1'b1;
    #1 check_reset_outputs("mid_exec_reset");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    #1 check("ready_after_reset", in_ready, 1);
    for (int i = 0; i < ALU_LAT + 3; i++) begin
      @(negedge CLK);
      check("no_done_after_reset", done_valid, 0);
    end
    run(1'b0, 4'd4, 3'd1, 3'd7, 3'd0, 1'b0, 16'h0000);
    check("dest_after_reset_A", A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
